vga_scan_reader: RTL and testbench

VGA_SCAN_READER -- requirements
Module: vga_scan_reader

---
 rtl/vga_scan_reader.sv | 178 +++++++++++++++++
 tb/tb_vga_scan_reader.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_reader.sv
// vga_scan_reader: 640x480 VGA raster generator that fetches a 256x240
// frame buffer, shown 2x scaled in both axes inside a window starting at
// X_OFFSET. Two-stage pipeline: stage 1 issues the frame-buffer read, and
// stage 2 registers the returned pixel together with the matching sync and
// blank signals, so all video outputs share the same raster position.
module vga_scan_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_OFFSET = 64
) (
  input  logic        vga_clock,
  input  logic        rst_n,
  input  logic [5:0]  q,
  output logic        rd,
  output logic [15:0] rd_addr,
  output logic        vga_frame_end,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [5:0]  pixel
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int SRC_COLS = 256;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END = 10'(V_ACTIVE);
  localparam logic [9:0] WIN_START = 10'(X_OFFSET);
  localparam logic [9:0] WIN_END   = 10'(X_OFFSET + 2 * SRC_COLS);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [5:0] NES_BLACK   = 6'h0F;
  localparam logic [5:0] BLANK_PIXEL = 6'h00;

  // Raster counters
  logic [9:0] h_cnt_reg;
  logic [9:0] h_cnt_next;
  logic [9:0] v_cnt_reg;
  logic [9:0] v_cnt_next;

  // Position decode (combinational, from the current counters)
  logic       visible;
  logic       in_window;
  logic       hsync_on;
  logic       vsync_on;
  logic       frame_mark;
  logic [9:0] col_off;
  logic [15:0] rd_addr_next;
  logic       unused_bits;

  // Stage 1: read request plus position flags carried alongside it
  logic        rd_reg;
  logic [15:0] rd_addr_reg;
  logic        frame_end_reg;
  logic        win_s1_reg;
  logic        vis_s1_reg;
  logic        hsync_s1_reg;
  logic        vsync_s1_reg;

  // Stage 2: video outputs, aligned with the returned frame-buffer data
  logic [5:0]  pixel_next;
  logic [5:0]  pixel_reg;
  logic        hsync_reg;
  logic        vsync_reg;
  logic        blank_n_reg;

  // Next raster position: h wraps every line, v advances on each h wrap.
  always_comb begin
    h_cnt_next = h_cnt_reg + 10'd1;
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      if (v_cnt_reg == V_LAST) begin
        v_cnt_next = '0;
      end else begin
        v_cnt_next = v_cnt_reg + 10'd1;
      end
    end
  end

  // Counter register; holds (0,0) while reset is asserted.
  always_ff @(posedge vga_clock) begin
    if (!rst_n) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else begin
      h_cnt_reg <= h_cnt_next;
      v_cnt_reg <= v_cnt_next;
    end
  end

  // Decode the current position; the read address halves both coordinates
  // so every source pixel covers a 2x2 block. Address holds outside window.
  always_comb begin
    visible    = (h_cnt_reg < H_VIS_END) && (v_cnt_reg < V_VIS_END);
    in_window  = (h_cnt_reg >= WIN_START) && (h_cnt_reg < WIN_END) &&
                 (v_cnt_reg < V_VIS_END);
    hsync_on   = (h_cnt_reg >= HS_START) && (h_cnt_reg < HS_END);
    vsync_on   = (v_cnt_reg >= VS_START) && (v_cnt_reg < VS_END);
    frame_mark = (h_cnt_reg == '0) && (v_cnt_reg == V_VIS_END);
    col_off    = h_cnt_reg - WIN_START;
    rd_addr_next = rd_addr_reg;
    if (in_window) begin
      rd_addr_next = {v_cnt_reg[8:1], col_off[8:1]};
    end
  end

  // Only the halved middle bits of the column offset form the address.
  assign unused_bits = ^{col_off[9], col_off[0]};

  // Stage 1: issue the read and carry position flags one cycle forward.
  always_ff @(posedge vga_clock) begin
    if (!rst_n) begin
      rd_reg        <= 1'b0;
      rd_addr_reg   <= '0;
      frame_end_reg <= 1'b0;
      win_s1_reg    <= 1'b0;
      vis_s1_reg    <= 1'b0;
      hsync_s1_reg  <= 1'b1;
      vsync_s1_reg  <= 1'b1;
    end else begin
      rd_reg        <= in_window;
      rd_addr_reg   <= rd_addr_next;
      frame_end_reg <= frame_mark;
      win_s1_reg    <= in_window;
      vis_s1_reg    <= visible;
      hsync_s1_reg  <= ~hsync_on;
      vsync_s1_reg  <= ~vsync_on;
    end
  end

  // Pixel select: frame-buffer data in the window, black border elsewhere
  // in the visible area, zero during blanking.
  always_comb begin
    pixel_next = BLANK_PIXEL;
    if (win_s1_reg) begin
      pixel_next = q;
    end else if (vis_s1_reg) begin
      pixel_next = NES_BLACK;
    end
  end

  // Stage 2: register pixel and syncs together so they share one position.
  always_ff @(posedge vga_clock) begin
    if (!rst_n) begin
      pixel_reg   <= BLANK_PIXEL;
      hsync_reg   <= 1'b1;
      vsync_reg   <= 1'b1;
      blank_n_reg <= 1'b0;
    end else begin
      pixel_reg   <= pixel_next;
      hsync_reg   <= hsync_s1_reg;
      vsync_reg   <= vsync_s1_reg;
      blank_n_reg <= vis_s1_reg;
    end
  end

  assign rd            = rd_reg;
  assign rd_addr       = rd_addr_reg;
  assign vga_frame_end = frame_end_reg;
  assign hsync         = hsync_reg;
  assign vsync         = vsync_reg;
  assign blank_n       = blank_n_reg;
  assign pixel         = pixel_reg;

endmodule

// File: tb/tb_vga_scan_reader.sv
// tb_vga_scan_reader: scoreboard bench for vga_scan_reader. The vertical
// timing is shortened (6 visible lines, 12 total) so several whole frames fit
// in a short run; horizontal timing keeps its default 800-cycle line.
module tb_vga_scan_reader;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 6;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 2;
  localparam int X_OFFSET = 64;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic        vga_clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  q = 6'h00;
  logic        rd;
  logic [15:0] rd_addr;
  logic        vga_frame_end;
  logic        hsync;
  logic        vsync;
  logic        blank_n;
  logic [5:0]  pixel;

  vga_scan_reader #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .X_OFFSET(X_OFFSET)
  ) dut (
    .vga_clock(vga_clock),
    .rst_n(rst_n),
    .q(q),
    .rd(rd),
    .rd_addr(rd_addr),
    .vga_frame_end(vga_frame_end),
    .hsync(hsync),
    .vsync(vsync),
    .blank_n(blank_n),
    .pixel(pixel)
  );

  always #5 vga_clock = ~vga_clock;

  typedef struct packed {
    logic        rd;
    logic [15:0] addr;
    logic        fe;
  } s1_t;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bn;
    logic [5:0] px;
  } s2_t;

  s1_t q1[$];
  s2_t q2[$];
  int checks = 0;
  int failures = 0;
  int hm = 0;
  int vm = 0;
  int n = 0;
  logic [15:0] last_addr = 16'h0000;
  bit const_mode = 1'b1;

  // Frame-buffer contents used when q is not held constant.
  function automatic logic [5:0] mem_data(input logic [15:0] a);
    return a[5:0] ^ a[13:8] ^ {a[7:6], a[15:14], 2'b01};
  endfunction

  // Expected outputs for the model raster position (hm, vm).
  task automatic push_expected();
    bit vis;
    bit win;
    s1_t e1;
    s2_t e2;
    logic [9:0] hr;
    logic [9:0] vv;
    vis = (hm < H_ACTIVE) && (vm < V_ACTIVE);
    win = (hm >= X_OFFSET) && (hm < X_OFFSET + 512) && (vm < V_ACTIVE);
    hr = 10'(hm - X_OFFSET);
    vv = 10'(vm);
    if (win) last_addr = {vv[8:1], hr[8:1]};
    e1.rd   = win;
    e1.addr = last_addr;
    e1.fe   = (hm == 0) && (vm == V_ACTIVE);
    e2.hs = !((hm >= H_ACTIVE + H_FP) && (hm < H_ACTIVE + H_FP + H_SYNC));
    e2.vs = !((vm >= V_ACTIVE + V_FP) && (vm < V_ACTIVE + V_FP + V_SYNC));
    e2.bn = vis;
    if (win) e2.px = const_mode ? 6'h2A : mem_data(last_addr);
    else     e2.px = vis ? 6'h0F : 6'h00;
    q1.push_back(e1);
    q2.push_back(e2);
  endtask

  // Memory answers the address now on rd_addr in time for the next edge.
  task automatic drive_q();
    if (const_mode)   q = 6'h2A;
    else if (rd)      q = mem_data(rd_addr);
    else              q = 6'h3F;
  endtask

  task automatic advance_model();
    hm++;
    if (hm == H_TOTAL) begin
      hm = 0;
      vm = (vm == V_TOTAL - 1) ? 0 : vm + 1;
    end
  endtask

  // One clock: push expectation for the current position, pop the entries
  // the pipeline is now presenting (stage 1 lags 1, stage 2 lags 2).
  task automatic step(output bit h1, output s1_t e1, output bit h2, output s2_t e2);
    @(negedge vga_clock);
    n++;
    push_expected();
    h1 = (q1.size() > 1);
    h2 = (q2.size() > 2);
    if (h1) e1 = q1.pop_front(); else e1 = '0;
    if (h2) e2 = q2.pop_front(); else e2 = '0;
    drive_q();
    advance_model();
  endtask

  // Called at a negedge while counters sit at (0,0): this is cycle n=0.
  task automatic release_reset();
    rst_n = 1'b1;
    q1.delete();
    q2.delete();
    hm = 0;
    vm = 0;
    n = 0;
    last_addr = 16'h0000;
    push_expected();
    drive_q();
    advance_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    const_mode = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge vga_clock);
      checks++;
      if ({rd, rd_addr, vga_frame_end, hsync, vsync, blank_n, pixel} !==
          {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00}) begin
        failures++;
        $display("FAIL reset_values cycle=%0d got rd=%b addr=%h fe=%b hs=%b vs=%b bn=%b px=%h", i,
                 rd, rd_addr, vga_frame_end, hsync, vsync, blank_n, pixel);
      end
    end
    release_reset();
    $display("test_reset: 20 reset cycles checked, reset released");
  endtask

  task automatic test_line_timing();
    bit h1, h2;
    s1_t e1;
    s2_t e2;
    int fall1 = -1, fall2 = -1, bn_rise = -1, bn_cnt = 0, hs_low = 0;
    logic hs_prev = 1'b1, bn_prev = 1'b0;
    for (int i = 0; i < 1600; i++) begin
      step(h1, e1, h2, e2);
      if (h1) begin
        checks++;
        if ({rd, rd_addr, vga_frame_end} !== e1) begin
          failures++;
          $display("FAIL line_stage1 n=%0d got=%h exp=%h", n, {rd, rd_addr, vga_frame_end}, e1);
        end
      end
      if (h2) begin
        checks++;
        if ({hsync, vsync, blank_n, pixel} !== e2) begin
          failures++;
          $display("FAIL line_stage2 n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, pixel}, e2);
        end
      end
      if (bn_rise < 0 && blank_n === 1'b1 && bn_prev === 1'b0) bn_rise = n;
      if (hs_prev === 1'b1 && hsync === 1'b0) begin
        if (fall1 < 0) fall1 = n;
        else if (fall2 < 0) fall2 = n;
      end
      if (n >= 2 && n < 802) begin
        if (blank_n === 1'b1) bn_cnt++;
        if (hsync === 1'b0) hs_low++;
      end
      hs_prev = hsync;
      bn_prev = blank_n;
    end
    checks++;
    if (bn_rise !== 2) begin
      failures++;
      $display("FAIL blank_rise got=%0d exp=2", bn_rise);
    end
    checks++;
    if (fall1 !== 658) begin
      failures++;
      $display("FAIL hsync_fall got=%0d exp=658", fall1);
    end
    checks++;
    if (fall2 - fall1 !== 800) begin
      failures++;
      $display("FAIL hsync_period got=%0d exp=800", fall2 - fall1);
    end
    checks++;
    if (hs_low !== 96) begin
      failures++;
      $display("FAIL hsync_low_width got=%0d exp=96", hs_low);
    end
    checks++;
    if (bn_cnt !== 640) begin
      failures++;
      $display("FAIL blank_high_count got=%0d exp=640", bn_cnt);
    end
    $display("test_line_timing: hsync fall=%0d period=%0d low=%0d blank_high=%0d",
             fall1, fall2 - fall1, hs_low, bn_cnt);
  endtask

  task automatic test_frame_timing();
    bit h1, h2;
    s1_t e1;
    s2_t e2;
    int fe_t[$];
    int vs_low = 0;
    while (n < 24100) begin
      step(h1, e1, h2, e2);
      if (h1) begin
        checks++;
        if ({rd, rd_addr, vga_frame_end} !== e1) begin
          failures++;
          $display("FAIL frame_stage1 n=%0d got=%h exp=%h", n, {rd, rd_addr, vga_frame_end}, e1);
        end
      end
      if (h2) begin
        checks++;
        if ({hsync, vsync, blank_n, pixel} !== e2) begin
          failures++;
          $display("FAIL frame_stage2 n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, pixel}, e2);
        end
      end
      if (vga_frame_end === 1'b1) fe_t.push_back(n);
      if (n >= 4801 && n < 14401 && vsync === 1'b0) vs_low++;
    end
    checks++;
    if (fe_t.size() !== 3) begin
      failures++;
      $display("FAIL frame_end_count got=%0d exp=3", fe_t.size());
    end
    if (fe_t.size() >= 3) begin
      checks++;
      if (fe_t[0] !== 4801) begin
        failures++;
        $display("FAIL frame_end_first got=%0d exp=4801", fe_t[0]);
      end
      checks++;
      if (fe_t[1] - fe_t[0] !== 9600 || fe_t[2] - fe_t[1] !== 9600) begin
        failures++;
        $display("FAIL frame_end_spacing got=%0d,%0d exp=9600", fe_t[1] - fe_t[0], fe_t[2] - fe_t[1]);
      end
    end
    checks++;
    if (vs_low !== 1600) begin
      failures++;
      $display("FAIL vsync_low_width got=%0d exp=1600", vs_low);
    end
    $display("test_frame_timing: frame_end pulses=%0d vsync_low=%0d", fe_t.size(), vs_low);
  endtask

  task automatic test_midframe_reset();
    bit h1, h2;
    s1_t e1;
    s2_t e2;
    int guard = 0;
    int fe_t[$];
    while (!(vm == 4 && hm == 300) && guard < 20000) begin
      step(h1, e1, h2, e2);
      if (h1) begin
        checks++;
        if ({rd, rd_addr, vga_frame_end} !== e1) begin
          failures++;
          $display("FAIL pre_reset_stage1 n=%0d got=%h exp=%h", n, {rd, rd_addr, vga_frame_end}, e1);
        end
      end
      if (h2) begin
        checks++;
        if ({hsync, vsync, blank_n, pixel} !== e2) begin
          failures++;
          $display("FAIL pre_reset_stage2 n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, pixel}, e2);
        end
      end
      guard++;
    end
    checks++;
    if (guard >= 20000) begin
      failures++;
      $display("FAIL midframe_search got=timeout exp=position(300,4)");
    end
    rst_n = 1'b0;
    const_mode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clock);
      checks++;
      if ({rd, rd_addr, vga_frame_end, hsync, vsync, blank_n, pixel} !==
          {1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 6'h00}) begin
        failures++;
        $display("FAIL midframe_reset_values cycle=%0d got rd=%b addr=%h fe=%b hs=%b vs=%b bn=%b px=%h", i,
                 rd, rd_addr, vga_frame_end, hsync, vsync, blank_n, pixel);
      end
    end
    release_reset();
    while (n < 4900) begin
      step(h1, e1, h2, e2);
      if (h1) begin
        checks++;
        if ({rd, rd_addr, vga_frame_end} !== e1) begin
          failures++;
          $display("FAIL restart_stage1 n=%0d got=%h exp=%h", n, {rd, rd_addr, vga_frame_end}, e1);
        end
      end
      if (h2) begin
        checks++;
        if ({hsync, vsync, blank_n, pixel} !== e2) begin
          failures++;
          $display("FAIL restart_stage2 n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, pixel}, e2);
        end
      end
      if (vga_frame_end === 1'b1) fe_t.push_back(n);
    end
    checks++;
    if (fe_t.size() !== 1 || (fe_t.size() == 1 && fe_t[0] !== 4801)) begin
      failures++;
      $display("FAIL restart_frame_end got_count=%0d got_first=%0d exp_count=1 exp_first=4801",
               fe_t.size(), (fe_t.size() > 0) ? fe_t[0] : -1);
    end
    $display("test_midframe_reset: restarted, frame_end pulses after restart=%0d", fe_t.size());
  endtask

  task automatic test_addr();
    bit h1, h2;
    s1_t e1;
    s2_t e2;
    int th[6] = '{64, 65, 66, 575, 63, 576};
    int tv[6] = '{0, 1, 2, 5, 0, 0};
    bit trd[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] ta[6] = '{16'h0000, 16'h0000, 16'h0101, 16'h02FF, 16'h0000, 16'h0000};
    int ph = -1, pv = -1, ch, cv, hits = 0;
    while (n < 14500) begin
      ch = hm;
      cv = vm;
      step(h1, e1, h2, e2);
      if (h1) begin
        checks++;
        if ({rd, rd_addr, vga_frame_end} !== e1) begin
          failures++;
          $display("FAIL addr_stage1 n=%0d got=%h exp=%h", n, {rd, rd_addr, vga_frame_end}, e1);
        end
      end
      if (h2) begin
        checks++;
        if ({hsync, vsync, blank_n, pixel} !== e2) begin
          failures++;
          $display("FAIL addr_stage2 n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, pixel}, e2);
        end
      end
      for (int i = 0; i < 6; i++) begin
        if (ph == th[i] && pv == tv[i]) begin
          hits++;
          checks++;
          if (rd !== trd[i] || (trd[i] && rd_addr !== ta[i])) begin
            failures++;
            $display("FAIL addr_point (%0d,%0d) got rd=%b addr=%h exp rd=%b addr=%h",
                     th[i], tv[i], rd, rd_addr, trd[i], ta[i]);
          end
          $display("test_addr: (%0d,%0d) rd=%b rd_addr=%h", th[i], tv[i], rd, rd_addr);
        end
      end
      ph = ch;
      pv = cv;
    end
    checks++;
    if (hits !== 6) begin
      failures++;
      $display("FAIL addr_point_hits got=%0d exp=6", hits);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_midframe_reset();
    test_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
